// File: rtl/block_match_pingpong_ram.sv
// Ping-pong pixel store: writer fills one half of every bank while read ports fetch pixels from the other half.
// Latency: 2 cycles from rd_en to rd_valid/rd_data (3 with BMPR_OUT_REG_EN defined).
// Backpressure: wr_ready drops when both halves are full; dropped writes/dones set sticky wr_overflow.
//
// Configuration macro: BMPR_OUT_REG_EN adds an output register stage on rd_data/rd_valid.
//
// Ports:
//   clk, reset (async, active-low)
//   write, wr_bank, wr_addr, wr_data, wr_frame_done -> writer side; wr_ready, wr_half report state
//   rd_en, rd_addr (packed per port) -> reader side; rd_data, rd_valid (packed per port) return pixels
//   rd_frame_done -> reader releases its half; frame_ready, rd_half report state
//   wr_overflow, rd_underflow -> sticky protocol-violation flags
//
// WR_DATA_W must be RD_DATA_W times a power of two of at least 2.
module block_match_pingpong_ram #(
  parameter int NUM_BANKS    = 3,
  parameter int NUM_RD_PORTS = 4,
  parameter int WR_DATA_W    = 16,
  parameter int RD_DATA_W    = 8,
  parameter int WR_AW        = 13,
  parameter logic [NUM_RD_PORTS*$clog2(NUM_BANKS)-1:0] PORT_BANK_MAP = {2'd1, 2'd2, 2'd1, 2'd0},
  localparam int BS   = $clog2(NUM_BANKS),
  localparam int SUBW = $clog2(WR_DATA_W / RD_DATA_W),
  localparam int RA   = WR_AW + SUBW
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            write,
  input  logic [BS-1:0]                   wr_bank,
  input  logic [WR_AW-1:0]                wr_addr,
  input  logic [WR_DATA_W-1:0]            wr_data,
  output logic                            wr_ready,
  input  logic                            wr_frame_done,
  output logic                            wr_half,
  input  logic [NUM_RD_PORTS-1:0]         rd_en,
  input  logic [NUM_RD_PORTS*RA-1:0]      rd_addr,
  output logic [NUM_RD_PORTS*RD_DATA_W-1:0] rd_data,
  output logic [NUM_RD_PORTS-1:0]         rd_valid,
  output logic                            frame_ready,
  input  logic                            rd_frame_done,
  output logic                            rd_half,
  output logic                            wr_overflow,
  output logic                            rd_underflow
);

  localparam int DEPTH = 2 ** (WR_AW + 1);
  localparam logic [BS:0] NB = (BS + 1)'(NUM_BANKS);

  logic [1:0]     full;
  logic [1:0]     full_nxt;
  logic           wr_done_ok;
  logic           rd_done_ok;
  logic           wr_accept;
  logic [WR_AW:0] wr_addr_phys;

  assign wr_ready     = !full[wr_half];
  assign frame_ready  = full[rd_half];
  assign wr_done_ok   = wr_frame_done && wr_ready;
  assign rd_done_ok   = rd_frame_done && frame_ready;
  // Out-of-range banks are silently ignored; they are not a flow-control violation.
  assign wr_accept    = write && wr_ready && ({1'b0, wr_bank} < NB);
  assign wr_addr_phys = {wr_half, wr_addr};

  // When both dones are legal in the same cycle the halves necessarily differ
  // (one is empty, the other full), so the two updates never collide.
  always_comb begin
    full_nxt = full;
    if (wr_done_ok) full_nxt[wr_half] = 1'b1;
    if (rd_done_ok) full_nxt[rd_half] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      full         <= 2'b00;
      wr_half      <= 1'b0;
      rd_half      <= 1'b0;
      wr_overflow  <= 1'b0;
      rd_underflow <= 1'b0;
    end else begin
      full <= full_nxt;
      if (wr_done_ok) wr_half <= !wr_half;
      if (rd_done_ok) rd_half <= !rd_half;
      if ((write || wr_frame_done) && !wr_ready) wr_overflow <= 1'b1;
      if (((|rd_en) || rd_frame_done) && !frame_ready) rd_underflow <= 1'b1;
    end
  end

  // One RAM replica per read port so every port gets its own read bandwidth;
  // writes are broadcast to every replica mapped to the target bank.
  for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_port
    localparam logic [BS-1:0] MAP = PORT_BANK_MAP[p*BS +: BS];

    logic [WR_DATA_W-1:0] mem [DEPTH];
    logic [WR_DATA_W-1:0] ram_q;
    logic [SUBW-1:0]      sub_q;
    logic [RA-1:0]        addr;
    logic                 s1_vld;
    logic                 s2_vld;
    logic [RD_DATA_W-1:0] s2_dat;

    assign addr = rd_addr[p*RA +: RA];

    // Storage and RAM output register: no reset so this maps onto block RAM.
    // The read half is captured here, so a later rd_half toggle cannot
    // redirect a read that is already in flight.
    always_ff @(posedge clk) begin
      if (wr_accept && (wr_bank == MAP)) mem[wr_addr_phys] <= wr_data;
      if (rd_en[p]) begin
        ram_q <= mem[{rd_half, addr[RA-1:SUBW]}];
        sub_q <= addr[SUBW-1:0];
      end
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        s1_vld <= 1'b0;
        s2_vld <= 1'b0;
        s2_dat <= '0;
      end else begin
        s1_vld <= rd_en[p] && frame_ready;
        s2_vld <= s1_vld;
        // Lane mux; data holds its last value between valid reads.
        if (s1_vld) s2_dat <= ram_q[RD_DATA_W*int'(sub_q) +: RD_DATA_W];
      end
    end

`ifdef BMPR_OUT_REG_EN
    logic                 s3_vld;
    logic [RD_DATA_W-1:0] s3_dat;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        s3_vld <= 1'b0;
        s3_dat <= '0;
      end else begin
        s3_vld <= s2_vld;
        if (s2_vld) s3_dat <= s2_dat;
      end
    end

    assign rd_valid[p]                       = s3_vld;
    assign rd_data[p*RD_DATA_W +: RD_DATA_W] = s3_dat;
`else
    assign rd_valid[p]                       = s2_vld;
    assign rd_data[p*RD_DATA_W +: RD_DATA_W] = s2_dat;
`endif
  end

endmodule
